alu_seq: RTL

Sequencer for the 8-bit ALU in the CPU datapath. Accepts an operation request from the instruction decoder and holds the ALU select stable for the operation's latency. It then arbitrates for the shared bus, enables the ALU result onto the bus for exactly one cycle, and reports completion, zero flag and divide-by-zero. It sits between the decoder/control FSM, the bus arbiter and the ALU register.

---
 rtl/alu_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- operation sequencer for the 8-bit datapath ALU.
//
// Accepts an operation from the decoder and holds the ALU select for the
// operation's execute latency. It then requests the shared bus and drives the
// ALU result onto it for exactly one cycle. Completion, the zero flag and
// divide-by-zero are reported as registered outputs. Every output is a
// register, so there is no combinational path from an input to an output.
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   clr_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   op        in   [1:0] 00 ADD, 01 SUB, 10 MLT, 11 DIV
//   reg_b     in   [WIDTH-1:0] register B, used for the divide-by-zero check
//   alu_res   in   [WIDTH-1:0] ALU result register, used for the zero flag
//   bus_gnt   in   grant from the bus arbiter
//   alu_sel   out  [1:0] select to the ALU, held from acceptance through DRIVE
//   alu_en    out  ALU bus output enable (one cycle)
//   bus_req   out  bus request to the arbiter
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   err_div0  out  one-cycle pulse for DIV with reg_b == 0
//   flag_z    out  zero flag of the last completed result
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             bus_gnt,
    output logic [1:0]       alu_sel,
    output logic             alu_en,
    output logic             bus_req,
    output logic             busy,
    output logic             done,
    output logic             err_div0,
    output logic             flag_z
);

    localparam logic [1:0] OP_MLT = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // The counter holds lat-1, so log2 of the largest latency is enough.
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_REQ,
        S_DRIVE
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;

    // Each output is set on the edge that enters the state in which the
    // output is active. This keeps the outputs registered and Moore-style.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            alu_sel  <= 2'b00;
            alu_en   <= 1'b0;
            bus_req  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_div0 <= 1'b0;
            flag_z   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. The
            // pulse outputs get a default here and are overridden below, so
            // each of them stays high for a single cycle.
            done     <= 1'b0;
            err_div0 <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        alu_sel <= op;
                        if (op == OP_DIV && reg_b == '0) begin
                            // Rejected at once: report the error and complete
                            // without executing or touching the bus.
                            err_div0 <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                            busy  <= 1'b1;
                            if (op == OP_MLT)      cnt <= MUL_CNT;
                            else if (op == OP_DIV) cnt <= DIV_CNT;
                            else                   cnt <= '0;
                        end
                    end
                end

                S_EXEC: begin
                    if (cnt == '0) begin
                        state   <= S_REQ;
                        bus_req <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_REQ: begin
                    if (bus_gnt) begin
                        state  <= S_DRIVE;
                        alu_en <= 1'b1;
                    end
                end

                S_DRIVE: begin
                    // The result sits on the bus during DRIVE. Capture its zero
                    // status as that cycle ends.
                    state   <= S_IDLE;
                    alu_en  <= 1'b0;
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    flag_z  <= (alu_res == '0);
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
